// File: rtl/myca_seq.sv
// Myca microprogram sequencer: executes one opcode per enabled step and
// produces the next microcode ROM address, with a bounded return stack and loop counter.
module myca_seq #(
    parameter int unsigned AW = 4,
    parameter int unsigned SD = 4,
    localparam int unsigned SPW = $clog2(SD + 1)
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           en,
    input  logic [2:0]     opc,
    input  logic [AW-1:0]  dir,
    input  logic           cnd,
    output logic [AW-1:0]  pc,
    output logic [AW-1:0]  cnt,
    output logic [SPW-1:0] sp,
    output logic           rdy,
    output logic           stp,
    output logic           err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NXT  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JT   = 3'd2,
        OP_JF   = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_LDC  = 3'd6,
        OP_DJNZ = 3'd7
    } op_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [AW-1:0]  r_pc;
    logic [AW-1:0]  r_cnt;
    logic [SPW-1:0] r_sp;
    logic           r_stp;
    logic           r_err;
    logic [AW-1:0]  r_stack [SD];

    op_t            w_op;
    logic [AW-1:0]  w_pc_inc;
    logic [AW-1:0]  w_cnt_dec;
    logic [AW-1:0]  w_top;
    logic           w_full;
    logic           w_empty;
    logic [AW-1:0]  w_pc_nxt;
    logic [AW-1:0]  w_cnt_nxt;
    logic [SPW-1:0] w_sp_nxt;
    logic           w_push;
    logic           w_fault;
    logic           w_exec;

    assign w_op      = op_t'(opc);
    assign w_pc_inc  = r_pc + AW'(1);
    assign w_cnt_dec = r_cnt - AW'(1);
    assign w_full    = (r_sp == SPW'(SD));
    assign w_empty   = (r_sp == '0);

    // Top of stack is the entry at index sp-1; a mux avoids an out-of-range index when empty.
    always_comb begin
        w_top = '0;
        for (int unsigned i = 0; i < SD; i++) begin
            if (r_sp == SPW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_sp_nxt    = r_sp;
        w_push      = 1'b0;
        w_fault     = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_FETCH: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (en) begin
                    w_exec = 1'b1;
                    case (w_op)
                        OP_NXT: w_pc_nxt = w_pc_inc;
                        OP_JMP: w_pc_nxt = dir;
                        OP_JT:  w_pc_nxt = cnd ? dir : w_pc_inc;
                        OP_JF:  w_pc_nxt = cnd ? w_pc_inc : dir;
                        OP_CALL: begin
                            if (w_full) begin
                                w_fault = 1'b1;
                            end else begin
                                w_push   = 1'b1;
                                w_sp_nxt = r_sp + SPW'(1);
                                w_pc_nxt = dir;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_fault = 1'b1;
                            end else begin
                                w_sp_nxt = r_sp - SPW'(1);
                                w_pc_nxt = w_top;
                            end
                        end
                        OP_LDC: begin
                            w_cnt_nxt = dir;
                            w_pc_nxt  = w_pc_inc;
                        end
                        OP_DJNZ: begin
                            if (r_cnt == '0) begin
                                w_pc_nxt = w_pc_inc;
                            end else begin
                                w_cnt_nxt = w_cnt_dec;
                                w_pc_nxt  = (w_cnt_dec != '0) ? dir : w_pc_inc;
                            end
                        end
                        default: w_pc_nxt = w_pc_inc;
                    endcase
                    w_state_nxt = w_fault ? S_ERR : S_FETCH;
                end
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_sp    <= '0;
            r_stp   <= 1'b0;
            r_err   <= 1'b0;
            for (int unsigned i = 0; i < SD; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_stp   <= w_exec;
            r_err   <= r_err | w_fault;
            // A faulting step leaves the architectural registers at their old values.
            if (!w_fault) begin
                r_pc  <= w_pc_nxt;
                r_cnt <= w_cnt_nxt;
                r_sp  <= w_sp_nxt;
            end
            for (int unsigned i = 0; i < SD; i++) begin
                if (w_push && (r_sp == SPW'(i))) begin
                    r_stack[i] <= w_pc_inc;
                end
            end
        end
    end

    assign pc  = r_pc;
    assign cnt = r_cnt;
    assign sp  = r_sp;
    assign rdy = (r_state == S_EXEC);
    assign stp = r_stp;
    assign err = r_err;

endmodule

// File: tb/tb_myca_seq.sv
// Self-checking bench for myca_seq: directed scenarios plus random microprograms
// compared against a queue-based reference model of the opcode rules.
module tb_myca_seq;

    localparam int AW  = 4;
    localparam int SD  = 4;
    localparam int NPC = 2 ** AW;

    logic        ck  = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [2:0]  opc = '0;
    logic [AW-1:0] dir = '0;
    logic        cnd = 1'b0;
    logic [AW-1:0] pc;
    logic [AW-1:0] cnt;
    logic [2:0]  sp;
    logic        rdy;
    logic        stp;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    int rom_op  [NPC];
    int rom_dir [NPC];
    bit rom_cnd [NPC];

    int m_pc;
    int m_cnt;
    int m_stk[$];
    bit m_err;

    int loop_pc  [7] = '{1, 2, 1, 2, 1, 2, 3};
    int loop_cnt [7] = '{3, 3, 2, 2, 1, 1, 0};

    always #5 ck = ~ck;

    myca_seq #(.AW(AW), .SD(SD)) dut (
        .ck (ck),
        .rst(rst),
        .en (en),
        .opc(opc),
        .dir(dir),
        .cnd(cnd),
        .pc (pc),
        .cnt(cnt),
        .sp (sp),
        .rdy(rdy),
        .stp(stp),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".pc"},  32'(pc),  m_pc);
        chk({tag, ".cnt"}, 32'(cnt), m_cnt);
        chk({tag, ".sp"},  32'(sp),  m_stk.size());
        chk({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_cnt = 0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_exec(input int op, input int d, input bit c);
        int inc;
        inc = (m_pc + 1) % NPC;
        case (op)
            0: m_pc = inc;
            1: m_pc = d;
            2: m_pc = c ? d : inc;
            3: m_pc = c ? inc : d;
            4: begin
                if (m_stk.size() == SD) m_err = 1'b1;
                else begin
                    m_stk.push_back(inc);
                    m_pc = d;
                end
            end
            5: begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else m_pc = m_stk.pop_back();
            end
            6: begin
                m_cnt = d;
                m_pc  = inc;
            end
            default: begin
                if (m_cnt == 0) m_pc = inc;
                else begin
                    m_cnt = m_cnt - 1;
                    m_pc  = (m_cnt != 0) ? d : inc;
                end
            end
        endcase
    endtask

    task automatic load_nxt();
        for (int i = 0; i < NPC; i++) begin
            rom_op[i]  = 0;
            rom_dir[i] = 0;
            rom_cnd[i] = 1'b0;
        end
    endtask

    // Called just after an active edge; rst rises between edges so the check is asynchronous.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk_state("rst");
        chk("rst.rdy", 32'(rdy), 0);
        chk("rst.stp", 32'(stp), 0);
        @(posedge ck); #1;
        rst = 1'b0;
        chk("rst.fetch_rdy", 32'(rdy), 0);
        @(posedge ck); #1;
        chk("rst.exec_rdy", 32'(rdy), 1);
        chk("rst.exec_stp", 32'(stp), 0);
    endtask

    task automatic do_step(input int gap, input bit fetch_en);
        bit was_err;
        int op;
        int d;
        bit c;
        was_err = m_err;
        op = rom_op[m_pc];
        d  = rom_dir[m_pc];
        c  = rom_cnd[m_pc];
        opc = 3'(op);
        dir = AW'(d);
        cnd = c;
        en  = 1'b1;
        @(posedge ck); #1;
        en = 1'b0;
        if (!was_err) model_exec(op, d, c);
        chk("step.stp", 32'(stp), 32'(!was_err));
        chk("step.rdy", 32'(rdy), 0);
        chk_state("step");
        opc = 3'($urandom_range(7));
        dir = AW'($urandom_range(NPC - 1));
        cnd = 1'($urandom_range(1));
        if (fetch_en) begin
            opc = 3'(1);
            dir = AW'((m_pc + 7) % NPC);
            en  = 1'b1;
        end
        @(posedge ck); #1;
        en = 1'b0;
        chk("fetch.stp", 32'(stp), 0);
        chk("fetch.rdy", 32'(rdy), 32'(!m_err));
        chk_state("fetch");
        repeat (gap) begin
            @(posedge ck); #1;
            chk("idle.rdy", 32'(rdy), 32'(!m_err));
            chk("idle.stp", 32'(stp), 0);
        end
    endtask

    initial begin
        #2;
        // Sequential advance with pc wrap
        load_nxt();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            do_step(2, 1'b0);
            chk("adv.pc", 32'(pc), (i + 1) % NPC);
        end

        // Conditional jumps
        load_nxt();
        rom_op[3] = 2; rom_dir[3] = 9; rom_cnd[3] = 1'b1;
        do_reset();
        repeat (4) do_step(0, 1'b0);
        chk("jt_taken.pc", 32'(pc), 9);
        rom_cnd[3] = 1'b0;
        do_reset();
        repeat (4) do_step(0, 1'b0);
        chk("jt_not.pc", 32'(pc), 4);
        rom_op[3] = 3;
        do_reset();
        repeat (4) do_step(0, 1'b0);
        chk("jf_taken.pc", 32'(pc), 9);
        rom_cnd[3] = 1'b1;
        do_reset();
        repeat (4) do_step(0, 1'b0);
        chk("jf_not.pc", 32'(pc), 4);

        // Loop counter
        load_nxt();
        rom_op[0] = 6; rom_dir[0] = 3;
        rom_op[2] = 7; rom_dir[2] = 1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_step(0, 1'b0);
            chk("loop.pc",  32'(pc),  loop_pc[i]);
            chk("loop.cnt", 32'(cnt), loop_cnt[i]);
        end

        // Stack overflow and underflow
        load_nxt();
        for (int a = 0; a < 5; a++) begin
            rom_op[a] = 4; rom_dir[a] = a + 1;
        end
        do_reset();
        repeat (4) do_step(0, 1'b0);
        chk("call4.sp", 32'(sp), 4);
        do_step(1, 1'b0);
        chk("ovf.err", 32'(err), 1);
        chk("ovf.pc",  32'(pc),  4);
        chk("ovf.sp",  32'(sp),  4);
        do_step(0, 1'b0);
        do_step(0, 1'b1);
        chk("ovf_frozen.pc", 32'(pc), 4);
        rom_op[0] = 5;
        do_reset();
        do_step(0, 1'b0);
        chk("unf.err", 32'(err), 1);
        chk("unf.pc",  32'(pc),  0);

        // Return-address wrap
        load_nxt();
        rom_op[0] = 1;  rom_dir[0] = 15;
        rom_op[15] = 4; rom_dir[15] = 5;
        rom_op[5] = 5;
        do_reset();
        repeat (2) do_step(0, 1'b0);
        chk("wrap_call.pc", 32'(pc), 5);
        chk("wrap_call.sp", 32'(sp), 1);
        do_step(0, 1'b0);
        chk("wrap_ret.pc", 32'(pc), 0);
        chk("wrap_ret.sp", 32'(sp), 0);

        // Enable during FETCH, then reset mid-run
        load_nxt();
        do_reset();
        do_step(1, 1'b1);
        chk("fetch_en.pc", 32'(pc), 1);
        rom_op[0] = 6; rom_dir[0] = 7;
        rom_op[1] = 4; rom_dir[1] = 3;
        rom_op[3] = 4; rom_dir[3] = 6;
        do_reset();
        repeat (3) do_step(1, 1'b0);
        chk("mid.sp",  32'(sp),  2);
        chk("mid.cnt", 32'(cnt), 7);
        do_reset();

        // Random microprograms
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < NPC; i++) begin
                rom_op[i]  = $urandom_range(7);
                rom_dir[i] = $urandom_range(NPC - 1);
                rom_cnd[i] = 1'($urandom_range(1));
            end
            do_reset();
            for (int s = 0; s < 40; s++) begin
                if (m_err && ($urandom_range(2) == 0)) do_reset();
                else do_step($urandom_range(2), ($urandom_range(3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/myca_seq.md
# myca_seq

Microprogram sequencer for the Myca microcoded controller. Each enabled step it executes the current microinstruction's opcode field and produces the next ROM address. Opcodes cover sequential advance, unconditional and conditional jumps on the multiplexed input condition, a bounded subroutine stack and a loop counter. It sits between the microcode ROM (registered read) and the input condition mux, and runs at system clock speed under a step-enable from the clock divider.

## Interface
- AW, 4, microprogram address width; also the width of the `dir` field and the loop counter.
- SD, 4, return-stack depth in entries (≥1).
- ck  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  step enable, one-`ck` pulse (1 Hz tick from divider).
- opc  in  3  opcode field of the ROM word currently addressed by `pc`.
- dir  in  AW  target address / counter load value field of the ROM word.
- cnd  in  1  condition bit selected by the input mux for this word.
- pc  out  AW  ROM address (program counter).
- cnt  out  AW  loop counter.
- sp  out  clog2(SD+1)  stack occupancy, 0..SD.
- rdy  out  1  high when the ROM word is valid and the next `en` will execute.
- stp  out  1  one-`ck` pulse in the cycle an instruction executes.
- err  out  1  sticky stack fault; sequencer frozen until reset.

## Operation
- States: FETCH, EXEC, ERR.
  - FETCH lasts exactly one `ck` (ROM read latency), then goes to EXEC.
  - EXEC waits for `en`. When `en`=1 it executes `opc` and goes to FETCH; on a fault it goes to ERR instead.
  - ERR is absorbing until `rst`.
- Opcodes (`pc+1` wraps modulo 2^AW):
  - 0 NXT: pc←pc+1.
  - 1 JMP: pc←dir.
  - 2 JT: pc←dir if cnd=1, else pc+1.
  - 3 JF: pc←dir if cnd=0, else pc+1.
  - 4 CALL: push pc+1, sp←sp+1, pc←dir. If sp==SD: fault, no push, pc unchanged.
  - 5 RET: pc←top, sp←sp−1. If sp==0: fault, pc unchanged.
  - 6 LDC: cnt←dir, pc←pc+1.
  - 7 DJNZ: if cnt==0, pc←pc+1 and cnt stays 0. Else cnt←cnt−1; pc←dir if the new cnt≠0, else pc+1.
- Every executed step returns to FETCH, including a jump to the same address.
- Stack is LIFO. The entry at index sp−1 is the top. Entries above sp are don't-care.
- Arithmetic is unsigned. The AW-bit increment wraps: 2^AW−1 → 0, including the CALL return address.

## Timing
- Reset values (asynchronous): pc=0, cnt=0, sp=0, err=0, rdy=0, stp=0, state=FETCH.
- After `rst` falls: one FETCH cycle, then rdy=1 from the second `ck` edge.
- `rdy`=1 exactly in EXEC. `en` is sampled only when rdy=1. An `en` during FETCH or ERR is ignored, not queued.
- Execution is on the `ck` edge where en=1 and rdy=1. pc/cnt/sp/err update at that edge. `stp` is high for the following cycle, while rdy=0 (FETCH).
- Minimum spacing between executed steps is 2 `ck`.
- `opc`/`dir`/`cnd` are used only at the executing edge.
- A fault sets err=1 at the executing edge. pc, cnt and sp keep their pre-instruction values. `stp` still pulses once. rdy stays 0 thereafter.
- `rst` asserted mid-step overrides everything immediately and clears the stack.

## Test plan
- Reset/advance: ROM is all NXT; release rst, give 17 `en` pulses spaced 4 `ck` → pc steps 1,2,…,15,0,1; one `stp` per pulse; rdy=0 for exactly 1 cycle after each pulse.
- Conditional jumps: pc=3 holds JT dir=9; cnd=1 → pc=9. Repeat with cnd=0 → pc=4. JF dir=9 with cnd=0 → pc=9.
- Loop: LDC 3 at addr 0, DJNZ dir=1 at addr 2, NXT at addr 1 → pc sequence 1,2,1,2,1,2,3 with cnt 3,3,2,2,1,1,0.
- Stack: four nested CALLs (SD=4) → sp=4. A fifth CALL → err=1, pc and sp unchanged, later `en` ignored. After reset, RET at pc=0 → err=1, pc=0.
- Call/return wrap: CALL dir=5 at pc=15 → pushes 0, pc=5. RET → pc=0, sp=0.
- Enable during FETCH and reset mid-run: an `en` pulse on the cycle right after a step → no execution, pc unchanged. Assert rst while sp=2, cnt=7 → all outputs return to reset values asynchronously.
